scratch_pad_dumper: RTL and testbench

Read-side companion to the scratchpad data memory. On command, it reads a contiguous range of 32-bit words through the scratchpad's synchronous read port and streams them out as bytes over a ready/valid byte interface, least-significant byte first. This is the inverse of the hex preload that fills the memory at elaboration. It sits between the scratchpad read port and the UART transmitter, and is used to dump memory contents after a program run for checking.

---
 rtl/scratch_pad_dumper.sv | 160 ++++++++++++++++
 tb/tb_scratch_pad_dumper.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_pad_dumper.sv
// ---------------------------------------------------------------------------
// scratch_pad_dumper
//
// Reads a contiguous range of 32-bit words from the scratchpad through its
// synchronous read port and streams them out as bytes, least-significant byte
// first, over a ready/valid byte interface (typically toward a UART TX).
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   io_start     in   one-cycle command strobe, sampled only in IDLE
//   io_startAddr in   byte address of the first word (bits [1:0] ignored)
//   io_wordCount in   number of words to dump (0 => immediate done)
//   io_busy      out  high while reading/sending (READ, CAPTURE, SEND)
//   io_done      out  one-cycle pulse after the last byte is accepted
//   io_rdAddress out  word-aligned scratchpad read address (0 in IDLE)
//   io_rdData    in   scratchpad read data, valid one cycle after address
//   io_tx_valid  out  byte available on io_tx_bits
//   io_tx_ready  in   downstream accepts the byte when valid && ready
//   io_tx_bits   out  byte being offered
// ---------------------------------------------------------------------------
module scratch_pad_dumper (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_start,
  input  logic [31:0] io_startAddr,
  input  logic [31:0] io_wordCount,
  output logic        io_busy,
  output logic        io_done,
  output logic [31:0] io_rdAddress,
  input  logic [31:0] io_rdData,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  output logic [7:0]  io_tx_bits
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_q,     state_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] buffer_q,    buffer_d;
  logic [1:0]  byte_idx_q,  byte_idx_d;

  logic        tx_fire_s;
  logic [7:0]  tx_byte_s;

  // All outputs decode directly from registered state, so io_tx_valid never
  // depends combinationally on io_tx_ready and drops as soon as reset hits.
  assign io_busy      = (state_q == ST_READ) || (state_q == ST_CAPTURE) ||
                        (state_q == ST_SEND);
  assign io_done      = (state_q == ST_DONE);
  assign io_tx_valid  = (state_q == ST_SEND);
  assign io_rdAddress = (state_q == ST_IDLE) ? 32'd0 : addr_q;
  assign io_tx_bits   = io_tx_valid ? tx_byte_s : 8'd0;

  assign tx_fire_s    = io_tx_valid && io_tx_ready;

  // Byte lane selection from the captured word, LSB first.
  always_comb begin
    tx_byte_s = 8'd0;
    case (byte_idx_q)
      2'd0:    tx_byte_s = buffer_q[7:0];
      2'd1:    tx_byte_s = buffer_q[15:8];
      2'd2:    tx_byte_s = buffer_q[23:16];
      2'd3:    tx_byte_s = buffer_q[31:24];
      default: tx_byte_s = 8'd0;
    endcase
  end

  // Next-state logic for the dump sequencer and its datapath registers.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    buffer_d    = buffer_q;
    byte_idx_d  = byte_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          if (io_wordCount != 32'd0) begin
            addr_d      = {io_startAddr[31:2], 2'b00};
            remaining_d = io_wordCount;
            state_d     = ST_READ;
          end else begin
            // Zero-length dump: report completion without touching memory.
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Address is already presented; memory registers it on this edge.
      ST_READ: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        buffer_d   = io_rdData;
        byte_idx_d = 2'd0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (tx_fire_s) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            remaining_d = remaining_q - 32'd1;
            if (remaining_q == 32'd1) begin
              state_d = ST_DONE;
            end else begin
              // 32-bit add wraps 0xFFFFFFFC to 0x00000000 naturally.
              addr_d  = addr_q + 32'd4;
              state_d = ST_READ;
            end
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          // Backpressure: hold byte, address and state.
          state_d = ST_SEND;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      remaining_q <= 32'd0;
      buffer_q    <= 32'd0;
      byte_idx_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

endmodule

// File: tb/tb_scratch_pad_dumper.sv
// ---------------------------------------------------------------------------
// tb_scratch_pad_dumper
//
// Directed plus randomized bench for scratch_pad_dumper. A synchronous-read
// memory model feeds the DUT; for each dump the expected byte stream, the
// expected per-word read addresses and the expected completion cycle are
// computed from the dump arguments with plain arithmetic and compared against
// what the DUT does, cycle by cycle.
// ---------------------------------------------------------------------------
module tb_scratch_pad_dumper;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start;
  logic [31:0] io_startAddr;
  logic [31:0] io_wordCount;
  logic        io_busy;
  logic        io_done;
  logic [31:0] io_rdAddress;
  logic [31:0] io_rdData;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_tx_bits;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem [logic [31:0]];
  int          stall_fixed[$];

  scratch_pad_dumper dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_startAddr (io_startAddr),
    .io_wordCount (io_wordCount),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_rdAddress (io_rdAddress),
    .io_rdData    (io_rdData),
    .io_tx_valid  (io_tx_valid),
    .io_tx_ready  (io_tx_ready),
    .io_tx_bits   (io_tx_bits)
  );

  always #5 clock = ~clock;

  // Memory contents: explicitly written words, otherwise an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // Synchronous read port: data appears one cycle after the address.
  always @(posedge clock) io_rdData <= mem_word(io_rdAddress);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  {31'd0, io_busy},     32'd0);
    check({tag, "_done"},  {31'd0, io_done},     32'd0);
    check({tag, "_valid"}, {31'd0, io_tx_valid}, 32'd0);
    check({tag, "_bits"},  {24'd0, io_tx_bits},  32'd0);
    check({tag, "_addr"},  io_rdAddress,         32'd0);
  endtask

  // One complete dump. Called at #1 after an edge with the DUT in IDLE.
  // rand_stall: max random ready-low cycles per byte (stall_fixed overrides
  // the first bytes). inject_cyc: relative cycle to pulse a stray io_start.
  task automatic run_dump(input logic [31:0] sa, input logic [31:0] cnt,
                          input int rand_stall, input int inject_cyc);
    logic [7:0]  exp_bytes[$];
    int          stalls[$];
    logic [31:0] base, word;
    logic [7:0]  held_bits;
    int          total, accepted, cyc, stall_cycles, waited, budget, first_valid;
    bit          done_seen, prev_final, held;

    base = {sa[31:2], 2'b00};
    for (int w = 0; w < int'(cnt); w++) begin
      word = mem_word(base + 32'(4 * w));
      for (int b = 0; b < 4; b++) exp_bytes.push_back(word[8*b +: 8]);
    end
    total  = exp_bytes.size();
    budget = 20;
    for (int k = 0; k < total; k++) begin
      stalls.push_back((k < stall_fixed.size()) ? stall_fixed[k] : int'($urandom_range(0, rand_stall)));
      budget += 2 + stalls[k];
    end

    io_startAddr = sa;
    io_wordCount = cnt;
    io_start     = 1'b1;
    io_tx_ready  = 1'b0;
    tick();
    io_start = 1'b0;

    cyc = 1; accepted = 0; stall_cycles = 0; waited = 0; first_valid = -1;
    done_seen = 1'b0; held = 1'b0; held_bits = 8'd0;
    prev_final = (total == 0);

    while (!done_seen && cyc < budget) begin
      io_start = (cyc == inject_cyc);
      if (cyc == inject_cyc) begin
        io_startAddr = $urandom;
        io_wordCount = $urandom_range(1, 9);
      end
      if (io_done) begin
        done_seen = 1'b1;
        check("done_after_last", {31'd0, prev_final}, 32'd1);
        check("done_count", 32'(accepted), 32'(total));
        check("done_busy", {31'd0, io_busy}, 32'd0);
        check("done_valid", {31'd0, io_tx_valid}, 32'd0);
        check("done_cycle", 32'(cyc), 32'(6 * (total / 4) + 1 + stall_cycles));
      end else begin
        check("busy", {31'd0, io_busy}, 32'd1);
        check("rd_addr", io_rdAddress, base + 32'(4 * (accepted / 4)));
        if (held) check("valid_held", {31'd0, io_tx_valid}, 32'd1);
        if (io_tx_valid) begin
          if (first_valid < 0) begin
            first_valid = cyc;
            check("first_valid_latency", 32'(cyc), 32'd3);
          end
          if (accepted < total) begin
            check("tx_bits", {24'd0, io_tx_bits}, {24'd0, exp_bytes[accepted]});
            if (held) check("stall_bits", {24'd0, io_tx_bits}, {24'd0, held_bits});
            io_tx_ready = (waited >= stalls[accepted]);
          end else begin
            check("extra_byte_valid", {31'd0, io_tx_valid}, 32'd0);
            io_tx_ready = 1'b1;
          end
          if (io_tx_ready) begin
            accepted++;
            waited     = 0;
            held       = 1'b0;
            prev_final = (accepted == total);
          end else begin
            waited++;
            stall_cycles++;
            held       = 1'b1;
            held_bits  = io_tx_bits;
            prev_final = 1'b0;
          end
        end else begin
          io_tx_ready = 1'($urandom_range(0, 1));
          held        = 1'b0;
          prev_final  = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    io_start    = 1'b0;
    io_tx_ready = 1'b0;
    if (!done_seen) check("done_timeout", {31'd0, done_seen}, 32'd1);
    check_idle("post_done");
  endtask

  initial begin
    logic [31:0] sa, cnt;
    logic [31:0] b4;

    reset        = 1'b1;
    io_start     = 1'b0;
    io_startAddr = 32'd0;
    io_wordCount = 32'd0;
    io_tx_ready  = 1'b0;
    #12;
    check_idle("reset");
    @(negedge clock);
    reset = 1'b0;
    tick();
    check_idle("after_reset");

    // Single word, ready tied high: bytes at N+3..N+6, done at N+7.
    mem[32'h10] = 32'hDDCCBBAA;
    run_dump(32'h10, 32'd1, 0, -1);

    // Multi-word with misaligned start address.
    mem[32'h100] = 32'h03020100;
    mem[32'h104] = 32'h07060504;
    mem[32'h108] = 32'h0B0A0908;
    run_dump(32'h102, 32'd3, 0, -1);

    // Backpressure: 5 stall cycles on byte 1, 2 on byte 3.
    stall_fixed = '{0, 5, 0, 2};
    run_dump(32'h10, 32'd1, 0, -1);
    stall_fixed.delete();

    // Zero count: done at N+1, no busy, no bytes.
    run_dump(32'h20, 32'd0, 0, -1);

    // Stray start during SEND of a 2-word dump is ignored.
    run_dump(32'h200, 32'd2, 0, 4);

    // Address wrap.
    run_dump(32'hFFFFFFFC, 32'd2, 0, -1);

    // Reset during SEND of byte 2 of a 4-word dump.
    mem[32'h40]  = 32'h44332211;
    b4           = mem[32'h40];
    io_startAddr = 32'h40;
    io_wordCount = 32'd4;
    io_start     = 1'b1;
    tick();
    io_start    = 1'b0;
    io_tx_ready = 1'b1;
    tick();
    tick();
    tick();
    io_tx_ready = 1'b0;
    check("rst_pre_valid", {31'd0, io_tx_valid}, 32'd1);
    check("rst_pre_bits", {24'd0, io_tx_bits}, {24'd0, b4[15:8]});
    #2;
    reset = 1'b1;
    #1;
    check_idle("rst_mid");
    tick();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_no_done", {31'd0, io_done}, 32'd0);
      check("rst_no_busy", {31'd0, io_busy}, 32'd0);
    end
    mem[32'h80] = 32'hCAFEF00D;
    run_dump(32'h80, 32'd1, 0, -1);

    // Randomized dumps: random addresses (some near the wrap point), counts,
    // memory contents, per-byte stalls and stray starts.
    for (int t = 0; t < 25; t++) begin
      sa  = $urandom;
      if ($urandom_range(0, 3) == 0) sa = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      cnt = 32'($urandom_range(0, 5));
      for (int w = 0; w < int'(cnt); w++) mem[{sa[31:2], 2'b00} + 32'(4 * w)] = $urandom;
      run_dump(sa, cnt, $urandom_range(0, 3),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
